vga_timing_driver: RTL and testbench

//  Generates 640x480@60 Hz VGA raster timing from a 25 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_driver.sv | 83 ++++++++
 tb/tb_vga_timing_driver.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and coordinate type.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FRONT  = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BACK   = 48;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FRONT  = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BACK   = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Sync pulses are driven low while asserted.
   localparam logic SYNC_ACTIVE = 1'b0;

   typedef logic [9:0] coord_t;

   // Inclusive window test used for the sync pulse span.
   function automatic logic in_window(coord_t value, coord_t first, coord_t last);
      return (value >= first) && (value <= last);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus the sync and active flags.
// sync and active describe the count value that will be loaded on the coming
// edge, so a register stage fed from them lines up with the count register.
// wrap is the terminal-count strobe and feeds the next axis as its enable.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE      = H_ACTIVE,
   parameter int unsigned FRONT       = H_FRONT,
   parameter int unsigned SYNC        = H_SYNC,
   parameter int unsigned BACK        = H_BACK,
   parameter logic        SYNC_ACTIVE = 1'b0
)(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   output logic [9:0] count,
   output logic       wrap,
   output logic       sync,
   output logic       active
);

   localparam int unsigned TOTAL      = ACTIVE + FRONT + SYNC + BACK;
   localparam coord_t      LAST       = coord_t'(TOTAL - 1);
   localparam coord_t      SYNC_FIRST = coord_t'(ACTIVE + FRONT);
   localparam coord_t      SYNC_LAST  = coord_t'(ACTIVE + FRONT + SYNC - 1);
   localparam coord_t      ACTIVE_END = coord_t'(ACTIVE);

   coord_t count_next;

   // Wrap at the configured total, never at the 10-bit overflow.
   assign wrap = enable && (count == LAST);

   // Next position: hold, step, or return to zero at the terminal count.
   always_comb begin
      count_next = count;
      if (wrap) begin
         count_next = '0;
      end else if (enable) begin
         count_next = count + coord_t'(1);
      end
   end

   assign sync   = in_window(count_next, SYNC_FIRST, SYNC_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign active = (count_next < ACTIVE_END);

   // Position register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/vga_timing_driver.sv
// VGA raster timing generator: horizontal and vertical axis counters with
// registered sync and active-area outputs, all aligned to the same (x,y).
module vga_timing_driver #(
   parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
   parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
   parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
   parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
   parameter logic        SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
)(
   input  logic       clock_25mhz,
   input  logic       reset_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       in_active_area
);

   import vga_timing_pkg::*;

   logic h_wrap;
   logic h_sync;
   logic h_active;
   logic v_wrap;
   logic v_sync;
   logic v_active;

   vga_axis_counter #(
      .ACTIVE      (H_ACTIVE),
      .FRONT       (H_FRONT),
      .SYNC        (H_SYNC),
      .BACK        (H_BACK),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_h_axis (
      .clock   (clock_25mhz),
      .reset_n (reset_n),
      .enable  (1'b1),
      .count   (x),
      .wrap    (h_wrap),
      .sync    (h_sync),
      .active  (h_active)
   );

   // Lines advance only on the pixel clock where the line wraps.
   vga_axis_counter #(
      .ACTIVE      (V_ACTIVE),
      .FRONT       (V_FRONT),
      .SYNC        (V_SYNC),
      .BACK        (V_BACK),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_v_axis (
      .clock   (clock_25mhz),
      .reset_n (reset_n),
      .enable  (h_wrap),
      .count   (y),
      .wrap    (v_wrap),
      .sync    (v_sync),
      .active  (v_active)
   );

   // Output register stage; the axis flags already look one position ahead.
   always_ff @(posedge clock_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         hsync          <= ~SYNC_ACTIVE;
         vsync          <= ~SYNC_ACTIVE;
         in_active_area <= 1'b1;
      end else begin
         hsync          <= h_sync;
         vsync          <= v_sync;
         in_active_area <= h_active && v_active;
      end
   end

   // A frame can only end on the last pixel of a line.
   a_frame_wrap_at_line_end: assert property (
      @(posedge clock_25mhz) disable iff (!reset_n) v_wrap |-> h_wrap
   );

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver: a full-size instance and a shrunken-geometry
// instance run in lockstep against an arithmetic raster model.
module tb_vga_timing_driver;

   localparam int HA = 640, HF = 16, HS = 96, HT = 800;
   localparam int VA = 480, VF = 10, VS = 2,  VT = 525;
   localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3, SHT = 16;
   localparam int SVA = 6, SVF = 2, SVS = 2, SVB = 3, SVT = 13;
   localparam int LONG = 60000;
   localparam logic [22:0] RESET_VEC = {10'd0, 10'd0, 3'b111};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [9:0] x, y, sx, sy;
   logic hsync, vsync, in_active_area, shs, svs, sact;
   logic [22:0] obs_m, obs_s;

   int n;
   int passed = 0;
   int total  = 0;

   always #20 clk = ~clk;

   vga_timing_driver dut (
      .clock_25mhz    (clk),
      .reset_n        (rst_n),
      .x              (x),
      .y              (y),
      .hsync          (hsync),
      .vsync          (vsync),
      .in_active_area (in_active_area)
   );

   vga_timing_driver #(
      .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
      .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
      .SYNC_ACTIVE (1'b0)
   ) dut_s (
      .clock_25mhz    (clk),
      .reset_n        (rst_n),
      .x              (sx),
      .y              (sy),
      .hsync          (shs),
      .vsync          (svs),
      .in_active_area (sact)
   );

   assign obs_m = {x, y, hsync, vsync, in_active_area};
   assign obs_s = {sx, sy, shs, svs, sact};

   // Raster position k clocks after (0,0), as {x, y, hsync, vsync, active}.
   function automatic logic [22:0] model(input int ha, input int hf, input int hs, input int ht,
                                         input int va, input int vf, input int vs, input int vt,
                                         input int k);
      int px, py;
      logic h, v, a;
      px = k % ht;
      py = (k / ht) % vt;
      h  = !((px >= ha + hf) && (px < ha + hf + hs));
      v  = !((py >= va + vf) && (py < va + vf + vs));
      a  = (px < ha) && (py < va);
      return {px[9:0], py[9:0], h, v, a};
   endfunction

   function automatic logic [22:0] model_m(input int k);
      return model(HA, HF, HS, HT, VA, VF, VS, VT, k);
   endfunction

   function automatic logic [22:0] model_s(input int k);
      return model(SHA, SHF, SHS, SHT, SVA, SVF, SVS, SVT, k);
   endfunction

   task automatic tick;
      @(posedge clk);
      if (rst_n) n++;
      #1;
   endtask

   task automatic do_release;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) tick();
      do_release();
   endtask

   task automatic test_reset;
      int cycles;
      cycles = 5 + $urandom_range(0, 4);
      rst_n = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         total++;
         if (obs_m !== RESET_VEC) $display("FAIL reset_main: got %h want %h", obs_m, RESET_VEC);
         else passed++;
         total++;
         if (obs_s !== RESET_VEC) $display("FAIL reset_small: got %h want %h", obs_s, RESET_VEC);
         else passed++;
      end
      do_release();
      total++;
      if (obs_m !== RESET_VEC) $display("FAIL release_hold: got %h want %h", obs_m, RESET_VEC);
      else passed++;
   endtask

   task automatic test_line;
      logic [22:0] e;
      int hs_low = 0, act_cnt = 0;
      for (int i = 0; i < 2 * HT + 100; i++) begin
         tick();
         e = model_m(n);
         total++;
         if (obs_m !== e) $display("FAIL line_main n=%0d: got %h want %h", n, obs_m, e);
         else passed++;
         e = model_s(n);
         total++;
         if (obs_s !== e) $display("FAIL line_small n=%0d: got %h want %h", n, obs_s, e);
         else passed++;
         if (n > HT && n <= 2 * HT) begin
            if (!hsync) hs_low++;
            if (in_active_area) act_cnt++;
         end
      end
      total++;
      if (hs_low !== 96) $display("FAIL hsync_width: got %0d want 96", hs_low);
      else passed++;
      total++;
      if (act_cnt !== 640) $display("FAIL active_width: got %0d want 640", act_cnt);
      else passed++;
   endtask

   task automatic test_frame;
      logic [22:0] e;
      int vs_low = 0, late_act = 0, wraps = 0;
      for (int i = 0; i < 2 * SHT * SVT; i++) begin
         tick();
         e = model_s(n);
         total++;
         if (obs_s !== e) $display("FAIL frame_small n=%0d: got %h want %h", n, obs_s, e);
         else passed++;
         if (i < SHT * SVT && !svs) vs_low++;
         if (sy >= SVA && sact) late_act++;
         if (sx == 0 && sy == 0 && sact) wraps++;
      end
      total++;
      if (vs_low !== SVS * SHT) $display("FAIL vsync_width: got %0d want %0d", vs_low, SVS * SHT);
      else passed++;
      total++;
      if (late_act !== 0) $display("FAIL blank_lines_active: got %0d want 0", late_act);
      else passed++;
      total++;
      if (wraps !== 2) $display("FAIL frame_wraps: got %0d want 2", wraps);
      else passed++;
   endtask

   task automatic test_long_run;
      logic [22:0] e;
      int hs_m = 0, hs_s = 0, vs_s = 0, last_vs = -1;
      int max_x = 0, max_y = 0, max_sx = 0, max_sy = 0;
      logic p_hs = 1'b1, p_shs = 1'b1, p_svs = 1'b1;
      do_reset();
      for (int i = 0; i < LONG; i++) begin
         tick();
         e = model_m(n);
         total++;
         if (obs_m !== e) $display("FAIL long_main n=%0d: got %h want %h", n, obs_m, e);
         else passed++;
         e = model_s(n);
         total++;
         if (obs_s !== e) $display("FAIL long_small n=%0d: got %h want %h", n, obs_s, e);
         else passed++;
         if (p_hs && !hsync) hs_m++;
         if (p_shs && !shs) hs_s++;
         if (p_svs && !svs) begin
            vs_s++;
            if (last_vs >= 0) begin
               total++;
               if (n - last_vs !== SHT * SVT)
                  $display("FAIL frame_period: got %0d want %0d", n - last_vs, SHT * SVT);
               else passed++;
            end
            last_vs = n;
         end
         p_hs = hsync; p_shs = shs; p_svs = svs;
         if (int'(x) > max_x) max_x = int'(x);
         if (int'(y) > max_y) max_y = int'(y);
         if (int'(sx) > max_sx) max_sx = int'(sx);
         if (int'(sy) > max_sy) max_sy = int'(sy);
      end
      total++;
      if (hs_m !== (LONG - (HA + HF)) / HT + 1)
         $display("FAIL hsync_pulses_main: got %0d want %0d", hs_m, (LONG - (HA + HF)) / HT + 1);
      else passed++;
      total++;
      if (hs_s !== (LONG - (SHA + SHF)) / SHT + 1)
         $display("FAIL hsync_pulses_small: got %0d want %0d", hs_s, (LONG - (SHA + SHF)) / SHT + 1);
      else passed++;
      total++;
      if (vs_s !== (LONG - (SVA + SVF) * SHT) / (SHT * SVT) + 1)
         $display("FAIL vsync_pulses_small: got %0d want %0d", vs_s,
                  (LONG - (SVA + SVF) * SHT) / (SHT * SVT) + 1);
      else passed++;
      total++;
      if (max_x !== HT - 1) $display("FAIL max_x: got %0d want %0d", max_x, HT - 1);
      else passed++;
      total++;
      if (max_y !== LONG / HT) $display("FAIL max_y: got %0d want %0d", max_y, LONG / HT);
      else passed++;
      total++;
      if (max_sx !== SHT - 1 || max_sy !== SVT - 1)
         $display("FAIL max_small: got %0d,%0d want %0d,%0d", max_sx, max_sy, SHT - 1, SVT - 1);
      else passed++;
   endtask

   task automatic mid_reset_resume(input bit use_small, input int tx, input int ty, input int bound);
      logic [22:0] e;
      bit found = 0;
      do_reset();
      for (int i = 0; i < bound && !found; i++) begin
         tick();
         if (!use_small && int'(x) == tx && int'(y) == ty) found = 1;
         if (use_small && int'(sx) == tx && int'(sy) == ty) found = 1;
      end
      total++;
      if (!found) begin
         $display("FAIL mid_reset_target: got none want (%0d,%0d)", tx, ty);
         return;
      end
      passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if (obs_m !== RESET_VEC || obs_s !== RESET_VEC)
         $display("FAIL mid_reset_immediate: got %h/%h want %h", obs_m, obs_s, RESET_VEC);
      else passed++;
      repeat (2) tick();
      total++;
      if (obs_m !== RESET_VEC || obs_s !== RESET_VEC)
         $display("FAIL mid_reset_hold: got %h/%h want %h", obs_m, obs_s, RESET_VEC);
      else passed++;
      do_release();
      for (int i = 0; i < HT + 100; i++) begin
         tick();
         e = model_m(n);
         total++;
         if (obs_m !== e) $display("FAIL resume_main n=%0d: got %h want %h", n, obs_m, e);
         else passed++;
         e = model_s(n);
         total++;
         if (obs_s !== e) $display("FAIL resume_small n=%0d: got %h want %h", n, obs_s, e);
         else passed++;
      end
   endtask

   task automatic test_mid_reset;
      mid_reset_resume(1'b0, 300, $urandom_range(1, 3), 5 * HT);
      mid_reset_resume(1'b1, $urandom_range(0, SHT - 1), $urandom_range(1, SVT - 1), 3 * SHT * SVT);
   endtask

   task automatic test_addressing;
      int run = 1, prev_ax = 0, max_ax = 0, max_say = 0;
      int ax, ay;
      do_reset();
      for (int i = 0; i < 4 * HT + 10; i++) begin
         tick();
         ax = int'(x[9:1]);
         ay = int'(y[9:1]);
         if (in_active_area) begin
            total++;
            if (ax !== (n % HT) / 2 || ay !== ((n / HT) % VT) / 2)
               $display("FAIL addr_main n=%0d: got %0d,%0d want %0d,%0d", n, ax, ay,
                        (n % HT) / 2, ((n / HT) % VT) / 2);
            else passed++;
            if (ax == prev_ax && run > 0) run++;
            else begin
               if (run > 0) begin
                  total++;
                  if (run !== 2) $display("FAIL addr_hold: got %0d want 2", run);
                  else passed++;
               end
               run = 1;
            end
            prev_ax = ax;
            if (ax > max_ax) max_ax = ax;
         end else if (run > 0) begin
            total++;
            if (run !== 2) $display("FAIL addr_hold_end: got %0d want 2", run);
            else passed++;
            run = 0;
         end
         if (sact) begin
            total++;
            if (int'(sy[9:1]) !== ((n / SHT) % SVT) / 2)
               $display("FAIL addr_small_y n=%0d: got %0d want %0d", n, sy[9:1], ((n / SHT) % SVT) / 2);
            else passed++;
            if (int'(sy[9:1]) > max_say) max_say = int'(sy[9:1]);
         end
      end
      total++;
      if (max_ax !== (HA - 1) / 2) $display("FAIL addr_x_span: got %0d want %0d", max_ax, (HA - 1) / 2);
      else passed++;
      total++;
      if (max_say !== (SVA - 1) / 2) $display("FAIL addr_y_span: got %0d want %0d", max_say, (SVA - 1) / 2);
      else passed++;
   endtask

   initial begin
      n = 0;
      test_reset();
      test_line();
      test_frame();
      test_long_run();
      test_mid_reset();
      test_addressing();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
